// File: rtl/varredura_display.sv
// varredura_display: time-multiplexed scan driver for a 4-digit common-anode
// 7-segment panel. Each enabled digit gets a blanking gap (all anodes off)
// followed by its lit slot; the 2-bit select only moves while the panel is dark.
// Optional feature macro: VARREDURA_BLINK_EN (frame counter + blink phase that
// suppresses the anode of digits flagged in blink_mask every other period).
module varredura_display #(
   parameter int unsigned TICKS_PER_DIGIT = 50000,
   parameter int unsigned BLANK_TICKS     = 500,
   parameter int unsigned BLINK_FRAMES    = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       hold,
   input  logic [3:0] digit_mask,
   input  logic [3:0] blink_mask,
   output logic       saida1Contador,
   output logic       saida2Contador,
   output logic [3:0] anodo,
   output logic       frame_done
);

   localparam int unsigned MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
   localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    anodo_q, anodo_d;
   logic          frame_done_q, frame_done_d;
   logic          blank_digit_s;
   logic          show_end_s;

   // Lowest set bit of a non-zero mask (0 when the mask is empty).
   function automatic logic [1:0] lowest_bit(input logic [3:0] mask);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) begin
            idx = 2'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Next set bit strictly above cur, wrapping 3->0; returns cur itself when it is the only bit.
   function automatic logic [1:0] next_bit(input logic [3:0] mask, input logic [1:0] cur);
      logic [1:0] idx;
      logic [1:0] cand;
      logic       found;
      idx   = cur;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = cur + 2'(k);
         if (!found && mask[cand]) begin
            idx   = cand;
            found = 1'b1;
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign show_end_s = (state_q == ST_SHOW) && !hold && (cnt_q == SHOW_LAST);

   // State and tick counter sequencing: IDLE -> BLANK -> SHOW -> BLANK ...
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (digit_mask != 4'b0000) begin
                  state_d = ST_BLANK;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_SHOW: begin
               if (hold) begin
                  cnt_d = cnt_q;
               end else if (cnt_q == SHOW_LAST) begin
                  cnt_d   = '0;
                  state_d = (digit_mask != 4'b0000) ? ST_BLANK : ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Select, frame pulse and anode pattern for the cycle after the edge.
   always_comb begin
      sel_d        = sel_q;
      frame_done_d = 1'b0;
      anodo_d      = 4'b1111;
      if (!enable) begin
         sel_d = sel_q;
      end else if ((state_q == ST_IDLE) && (digit_mask != 4'b0000)) begin
         sel_d = lowest_bit(digit_mask);
      end else if (show_end_s && (digit_mask != 4'b0000)) begin
         sel_d        = next_bit(digit_mask, sel_q);
         frame_done_d = (next_bit(digit_mask, sel_q) <= sel_q);
      end else begin
         sel_d = sel_q;
      end
      if ((state_d == ST_SHOW) && !blank_digit_s) begin
         anodo_d = ~(4'b0001 << sel_d);
      end else begin
         anodo_d = 4'b1111;
      end
   end

   // Scan registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sel_q        <= 2'b00;
         anodo_q      <= 4'b1111;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         anodo_q      <= anodo_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef VARREDURA_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          phase_q, phase_d;

   // Count completed frames and flip the blink phase every BLINK_FRAMES frames.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_done_d) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
         end
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Blink state registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         frame_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign blank_digit_s = phase_q & blink_mask[sel_q];
`else
   logic unused_blink_s;
   assign unused_blink_s = (^blink_mask) ^ (BLINK_FRAMES == 32'd0);
   assign blank_digit_s  = 1'b0;
`endif

   assign saida1Contador = sel_q[1];
   assign saida2Contador = sel_q[0];
   assign anodo          = anodo_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_varredura_display.sv
// Self-checking bench for varredura_display: a visit-time behavioural model is
// compared with the DUT every cycle, plus literal timing expectations.
module tb_varredura_display;

   localparam int T  = 4;
   localparam int B  = 2;
   localparam int BF = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       hold = 1'b0;
   logic [3:0] digit_mask = 4'b0000;
   logic [3:0] blink_mask = 4'b0000;
   logic       saida1Contador;
   logic       saida2Contador;
   logic [3:0] anodo;
   logic       frame_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // behavioural model: active flag, digit being visited, cycles elapsed in visit
   bit         m_active = 1'b0;
   int         m_digit  = 0;
   int         m_t      = 0;
   int         m_frames = 0;
   bit         m_phase  = 1'b0;
   bit         m_fd     = 1'b0;
   logic [3:0] m_anodo  = 4'b1111;

   varredura_display #(
      .TICKS_PER_DIGIT(T),
      .BLANK_TICKS    (B),
      .BLINK_FRAMES   (BF)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .hold          (hold),
      .digit_mask    (digit_mask),
      .blink_mask    (blink_mask),
      .saida1Contador(saida1Contador),
      .saida2Contador(saida2Contador),
      .anodo         (anodo),
      .frame_done    (frame_done)
   );

   always #5 clock = ~clock;

   function automatic int first_set(input logic [3:0] mask);
      for (int i = 0; i < 4; i++) if (mask[i]) return i;
      return 0;
   endfunction

   function automatic int next_set(input logic [3:0] mask, input int cur);
      for (int k = 1; k <= 4; k++) if (mask[(cur + k) % 4]) return (cur + k) % 4;
      return cur;
   endfunction

   // model update on each rising edge from the inputs sampled there
   always @(posedge clock) begin : model
      int  nd;
      bit  dark;
      m_fd = 1'b0;
      if (!reset) begin
         m_active = 1'b0; m_digit = 0; m_t = 0; m_frames = 0; m_phase = 1'b0;
      end else if (!enable) begin
         m_active = 1'b0; m_t = 0;
      end else if (!m_active) begin
         if (digit_mask != 4'b0000) begin
            m_active = 1'b1; m_t = 0; m_digit = first_set(digit_mask);
         end
      end else if (m_t >= B && hold) begin
         m_t = m_t;
      end else if (m_t == B + T - 1) begin
         if (digit_mask == 4'b0000) begin
            m_active = 1'b0; m_t = 0;
         end else begin
            nd = next_set(digit_mask, m_digit);
            m_fd = (nd <= m_digit);
            m_digit = nd;
            m_t = 0;
         end
      end else begin
         m_t = m_t + 1;
      end
      dark = 1'b0;
`ifdef VARREDURA_BLINK_EN
      if (m_fd) begin
         m_frames = m_frames + 1;
         if (m_frames == BF) begin
            m_frames = 0;
            m_phase = !m_phase;
         end
      end
      dark = m_phase && blink_mask[m_digit];
`endif
      m_anodo = 4'b1111;
      if (m_active && m_t >= B && !dark) m_anodo[m_digit] = 1'b0;
   end

   // advance to the next falling edge and compare DUT against the model
   task automatic step();
      logic [1:0] esel;
      @(negedge clock);
      cyc++;
      esel = 2'(m_digit);
      checks++;
      if (anodo !== m_anodo || {saida1Contador, saida2Contador} !== esel || frame_done !== m_fd) begin
         errors++;
         $display("FAIL model_cmp cyc=%0d got anodo=%b sel=%b fd=%b want anodo=%b sel=%b fd=%b",
                  cyc, anodo, {saida1Contador, saida2Contador}, frame_done, m_anodo, esel, m_fd);
      end
   endtask

   task automatic lit_check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic wait_fd(input string name, output int at);
      bit seen;
      seen = 1'b0;
      at = 0;
      for (int k = 0; k < 200; k++) begin
         step();
         if (frame_done === 1'b1) begin
            at = cyc; seen = 1'b1; break;
         end
      end
      lit_check({name, "_fd_timeout"}, int'(seen), 1);
   endtask

   task automatic wait_anodo(input string name, input logic [3:0] pat, input bit eq);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         step();
         if ((anodo === pat) == eq) begin
            seen = 1'b1; break;
         end
      end
      lit_check({name, "_timeout"}, int'(seen), 1);
   endtask

   initial begin : stim
      int a, b, c, lit;
      int frame_lit[6];
      int f;
      // 1: reset with arbitrary inputs
      reset = 1'b0; enable = 1'b1; digit_mask = 4'b1011; hold = 1'b1;
      step();
      step();
      lit_check("reset_anodo", int'(anodo), 15);
      lit_check("reset_sel", int'({saida1Contador, saida2Contador}), 0);
      lit_check("reset_fd", int'(frame_done), 0);
      hold = 1'b0; digit_mask = 4'b1111; reset = 1'b1;

      // 2: full mask, frame = 4 digits * 6 cycles
      wait_fd("full", a);
      wait_fd("full", b);
      lit_check("frame_period_1111", b - a, 24);

      // 3: mask 0101 alternates digits 0 and 2
      digit_mask = 4'b0101;
      wait_fd("m0101", a);
      wait_fd("m0101", b);
      wait_fd("m0101", c);
      lit_check("frame_period_0101", c - b, 12);

      // 4: hold freezes digit 1 for nine extra cycles
      digit_mask = 4'b1111;
      wait_anodo("hold_wait", 4'b1101, 1'b1);
      lit = 1;
      hold = 1'b1;
      for (int k = 1; k < 40; k++) begin
         step();
         if (k == 9) hold = 1'b0;
         if (anodo === 4'b1101) lit++;
         else break;
      end
      lit_check("hold_lit_cycles", lit, 13);

      // 5a: enable drop mid SHOW, restart from lowest bit
      wait_anodo("en_wait", 4'b1111, 1'b0);
      enable = 1'b0;
      step();
      lit_check("enable_off_anodo", int'(anodo), 15);
      digit_mask = 4'b1100; enable = 1'b1;
      wait_anodo("restart", 4'b1111, 1'b0);
      lit_check("restart_lowest", int'(anodo), 11);
      // 5b: reset mid BLANK
      wait_fd("rst", a);
      reset = 1'b0;
      step();
      lit_check("rst_blank_anodo", int'(anodo), 15);
      lit_check("rst_blank_sel", int'({saida1Contador, saida2Contador}), 0);
      reset = 1'b1;
      wait_anodo("rst_restart", 4'b1111, 1'b0);
      lit_check("rst_restart_lowest", int'(anodo), 11);

`ifdef VARREDURA_BLINK_EN
      // 6: digit 1 dark in frames 3-4
      reset = 1'b0; step(); reset = 1'b1;
      digit_mask = 4'b1111; blink_mask = 4'b0010;
      for (int i = 0; i < 6; i++) frame_lit[i] = 0;
      f = 0;
      for (int k = 0; k < 400 && f < 6; k++) begin
         step();
         if (anodo === 4'b1101) frame_lit[f]++;
         if (frame_done === 1'b1) f++;
      end
      lit_check("blink_frames_seen", f, 6);
      lit_check("blink_f1", frame_lit[0], 4);
      lit_check("blink_f2", frame_lit[1], 4);
      lit_check("blink_f3", frame_lit[2], 0);
      lit_check("blink_f4", frame_lit[3], 0);
      lit_check("blink_f5", frame_lit[4], 4);
      lit_check("blink_f6", frame_lit[5], 4);
`else
      frame_lit[0] = 0; f = 0;
`endif

      // random phase checked cycle by cycle against the model
      for (int k = 0; k < 4000; k++) begin
         reset  = ($urandom_range(0, 299) != 0);
         enable = ($urandom_range(0, 99) != 0);
         hold   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 39) == 0) digit_mask = 4'($urandom);
         if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
